mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameters: AW, 32, address width; DW, 32, data width; TIMEOUT, 255, max bus-wait cycles before abort (0 = no timeout).
REQ-002 SHALL have ports: i_clk  in  1  sole clock; i_rst_n  in  1  asynchronous active-low reset.
REQ-003 SHALL have port: i_clk_en  in  1  global clock enable; no state changes while low.
REQ-004 SHALL have fetch-port ports: i_f_read  in  1  read request, level; i_f_addr  in  AW  address; o_f_data  out  DW  read data; o_f_ack  out  1  done pulse; o_f_err  out  1  timeout pulse.
REQ-005 SHALL have LSU-port ports: i_l_read  in  1; i_l_write  in  1; i_l_addr  in  AW; i_l_wdata  in  DW; i_l_wstrb  in  DW/8; o_l_data  out  DW; o_l_ack  out  1; o_l_err  out  1.
REQ-006 SHALL have bus ports: o_bus_stb  out  1  request valid, level; o_bus_we  out  1; o_bus_addr  out  AW; o_bus_wdata  out  DW; o_bus_wstrb  out  DW/8; i_bus_data  in  DW; i_bus_ack  in  1.
REQ-007 SHALL have port: o_busy  out  1  high in any state other than IDLE.

Function
REQ-008 SHALL implement FSM IDLE -> BUS -> RESP -> IDLE; all transitions and register updates qualified by i_clk_en.
REQ-009 In IDLE with any request pending, SHALL latch the winner's addr, we, wdata, and wstrb into bus registers, record the grant owner, and enter BUS with o_bus_stb=1 the next cycle.
REQ-010 Fixed-priority mode: LSU SHALL win over fetch when both request in the same cycle.
REQ-011 A request is i_f_read, or i_l_read|i_l_write; i_l_read and i_l_write together SHALL be treated as a write.
REQ-012 In BUS, o_bus_stb and all o_bus_* SHALL hold stable until i_bus_ack; on ack SHALL capture i_bus_data, drop o_bus_stb, and enter RESP.
REQ-013 In RESP, SHALL pulse the owner's ack high for exactly one cycle with captured data on o_*_data, then return to IDLE; non-owner ack stays 0.
REQ-014 Requests seen during BUS or RESP SHALL be ignored; requesters SHALL hold request until ack and deassert on the ack cycle.
REQ-015 Latency: request at cycle N in IDLE -> stb at N+1; bus ack at cycle M -> requester ack at M+1; minimum turnaround 3 cycles.
REQ-016 o_*_data SHALL hold their last captured value until the next response to that port; write responses SHALL not update o_l_data.
REQ-017 With TIMEOUT>0, a counter SHALL run in BUS; after TIMEOUT cycles without ack, SHALL drop stb and enter RESP, pulsing owner's ack and err together, with data unchanged.
REQ-018 i_bus_ack outside BUS SHALL be ignored.

Reset
REQ-019 Reset SHALL force IDLE, all outputs 0, timeout counter 0, and round-robin pointer to fetch; reset mid-BUS SHALL drop o_bus_stb immediately (asynchronously).

Configuration
REQ-020 Macro MEM_ARB_RR_EN defined: round-robin arbitration; on a simultaneous request, the port not granted last SHALL win; the pointer updates on each grant.
REQ-021 Macro MEM_ARB_RR_EN undefined: fixed priority per REQ-010; no pointer register.

Structure
REQ-022 Shared package SHALL hold the FSM state enum (IDLE, BUS, RESP) and the owner enum (OWN_F, OWN_L).
REQ-023 Arbitration decision SHALL be sub-module mem_arb_pick (combinational winner plus optional RR pointer); FSM and datapath stay in mem_arbiter.

Verification
REQ-024 Fetch read 0x100, bus acks after 2 cycles with 0x00000013 -> o_f_data=0x00000013, o_f_ack one pulse, o_l_ack=0.
REQ-025 Fetch and LSU read same cycle, fixed mode -> LSU granted first, fetch granted after; RR mode with last grant LSU -> fetch first.
REQ-026 LSU write addr 0x2000, wdata 0xDEADBEEF, wstrb 0xF -> o_bus_we=1 and fields stable until ack; o_l_data unchanged.
REQ-027 TIMEOUT=4 and no bus ack -> stb drops after 4 cycles; o_f_ack and o_f_err pulse together.
REQ-028 i_rst_n low mid-BUS -> o_bus_stb=0 without a clock edge; after release, a fresh fetch read completes normally.
REQ-029 i_clk_en low during BUS with ack present -> no state change; completes when enable returns with ack.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: types and helpers shared by the memory arbiter.
//   state_t  : arbiter FSM states (IDLE, BUS, RESP)
//   owner_t  : which requester currently owns the bus (OWN_F fetch, OWN_L LSU)
//   cnt_width: width of a counter that counts from 0 to max_val-1
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic {
    OWN_F = 1'b0,
    OWN_L = 1'b1
  } owner_t;

  function automatic int cnt_width(input int max_val);
    return (max_val > 1) ? $clog2(max_val) : 1;
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: combinational winner selection between fetch and LSU.
// Build option: MEM_ARB_RR_EN defined -> round-robin on simultaneous requests
// (priority register points at fetch after reset and moves to the other
// port on every grant); undefined -> LSU always wins, no state.
// Ports:
//   i_clk, i_rst_n, i_clk_en : clock, async active-low reset, clock enable
//   i_f_req, i_l_req         : pending requests from fetch / LSU
//   i_grant                  : a grant is being issued this cycle
//   o_pick                   : winning port
module mem_arb_pick
  import mem_arbiter_pkg::*;
(
  input  logic   i_clk,
  input  logic   i_rst_n,
  input  logic   i_clk_en,
  input  logic   i_f_req,
  input  logic   i_l_req,
  input  logic   i_grant,
  output owner_t o_pick
);

`ifdef MEM_ARB_RR_EN
  // Port favoured on the next tie.
  owner_t prio;

  always_comb begin
    o_pick = OWN_F;
    if (i_f_req && i_l_req) begin
      o_pick = prio;
    end else if (i_l_req) begin
      o_pick = OWN_L;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      prio <= OWN_F;
    end else if (i_clk_en && i_grant) begin
      prio <= (o_pick == OWN_F) ? OWN_L : OWN_F;
    end
  end
`else
  always_comb begin
    o_pick = i_l_req ? OWN_L : OWN_F;
  end

  logic unused_pick;
  assign unused_pick = &{1'b0, i_clk, i_rst_n, i_clk_en, i_f_req, i_grant};
`endif

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-outstanding bus between an instruction
// fetch port and a load/store port. IDLE -> BUS -> RESP -> IDLE.
// Build option: MEM_ARB_RR_EN selects round-robin arbitration (see mem_arb_pick).
// Parameters: AW address width, DW data width, TIMEOUT bus-wait limit (0 = none).
// Ports:
//   i_clk, i_rst_n, i_clk_en          : clock, async active-low reset, enable
//   i_f_read/i_f_addr                 : fetch read request (level) and address
//   o_f_data/o_f_ack/o_f_err          : fetch read data, done pulse, timeout pulse
//   i_l_read/i_l_write/i_l_addr/
//   i_l_wdata/i_l_wstrb               : LSU request (read+write means write)
//   o_l_data/o_l_ack/o_l_err          : LSU read data, done pulse, timeout pulse
//   o_bus_stb/we/addr/wdata/wstrb     : bus request, held until i_bus_ack
//   i_bus_data/i_bus_ack              : bus response
//   o_busy                            : FSM not in IDLE
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_clk_en,
  input  logic            i_f_read,
  input  logic [AW-1:0]   i_f_addr,
  output logic [DW-1:0]   o_f_data,
  output logic            o_f_ack,
  output logic            o_f_err,
  input  logic            i_l_read,
  input  logic            i_l_write,
  input  logic [AW-1:0]   i_l_addr,
  input  logic [DW-1:0]   i_l_wdata,
  input  logic [DW/8-1:0] i_l_wstrb,
  output logic [DW-1:0]   o_l_data,
  output logic            o_l_ack,
  output logic            o_l_err,
  output logic            o_bus_stb,
  output logic            o_bus_we,
  output logic [AW-1:0]   o_bus_addr,
  output logic [DW-1:0]   o_bus_wdata,
  output logic [DW/8-1:0] o_bus_wstrb,
  input  logic [DW-1:0]   i_bus_data,
  input  logic            i_bus_ack,
  output logic            o_busy
);

  localparam int CW = cnt_width(TIMEOUT);

  state_t        state, state_d;
  owner_t        owner, pick;
  logic          f_req, l_req, any_req;
  logic          grant, bus_done, tmo_hit;
  logic [CW-1:0] tmo_cnt;

  assign f_req   = i_f_read;
  assign l_req   = i_l_read | i_l_write;
  assign any_req = f_req | l_req;
  // Counter holds 0..TIMEOUT-1, so the last waiting cycle is the one at TIMEOUT-1.
  assign tmo_hit = (TIMEOUT != 0) && (tmo_cnt == CW'(TIMEOUT - 1));
  assign o_busy  = (state != IDLE);

  mem_arb_pick u_pick (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_clk_en (i_clk_en),
    .i_f_req  (f_req),
    .i_l_req  (l_req),
    .i_grant  (grant),
    .o_pick   (pick)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
    end else if (i_clk_en) begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d  = state;
    grant    = 1'b0;
    bus_done = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) begin
          grant   = 1'b1;
          state_d = BUS;
        end
      end
      BUS: begin
        // A real ack in the same cycle as the timeout wins.
        if (i_bus_ack || tmo_hit) begin
          bus_done = 1'b1;
          state_d  = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      owner       <= OWN_F;
      tmo_cnt     <= '0;
      o_bus_stb   <= 1'b0;
      o_bus_we    <= 1'b0;
      o_bus_addr  <= '0;
      o_bus_wdata <= '0;
      o_bus_wstrb <= '0;
      o_f_data    <= '0;
      o_l_data    <= '0;
      o_f_ack     <= 1'b0;
      o_l_ack     <= 1'b0;
      o_f_err     <= 1'b0;
      o_l_err     <= 1'b0;
    end else if (i_clk_en) begin
      o_f_ack <= 1'b0;
      o_l_ack <= 1'b0;
      o_f_err <= 1'b0;
      o_l_err <= 1'b0;

      if (grant) begin
        owner     <= pick;
        o_bus_stb <= 1'b1;
        if (pick == OWN_L) begin
          o_bus_we    <= i_l_write;
          o_bus_addr  <= i_l_addr;
          o_bus_wdata <= i_l_wdata;
          o_bus_wstrb <= i_l_wstrb;
        end else begin
          o_bus_we    <= 1'b0;
          o_bus_addr  <= i_f_addr;
          o_bus_wdata <= '0;
          o_bus_wstrb <= '0;
        end
      end

      if (bus_done) begin
        o_bus_stb <= 1'b0;
        tmo_cnt   <= '0;
        if (owner == OWN_F) begin
          o_f_ack <= 1'b1;
          o_f_err <= ~i_bus_ack;
          if (i_bus_ack) begin
            o_f_data <= i_bus_data;
          end
        end else begin
          o_l_ack <= 1'b1;
          o_l_err <= ~i_bus_ack;
          // Write completions leave the last read data in place.
          if (i_bus_ack && !o_bus_we) begin
            o_l_data <= i_bus_data;
          end
        end
      end else if (state == BUS && TIMEOUT != 0) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
    end
  end

endmodule
